// File: rtl/sw_input_port.sv
// sw_input_port: synchronised, debounced switch input peripheral with level, sticky-rise, change counter and optional masked irq.
// Build option: define SW_IRQ_EN to add the writable MASK register and the registered irq output.
module sw_input_port #(
    parameter int TICK_DIV   = 50000,
    parameter int DB_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [15:0] sw,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     r_presc;
    logic [15:0]       r_sync1, r_sync2, r_level, r_rise, r_chgcnt;
    logic [15:0][2:0]  r_cnt;
    logic [15:0][2:0]  w_cnt_nx;
    logic [15:0]       w_level_nx, w_mask;
    logic              w_tick, w_rd, w_wr, w_rclr, w_chg;
    logic              w_unused;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));
    assign w_rd   = cs && rd;
    assign w_wr   = cs && wr;
    assign w_rclr = w_rd && !wr && (addr == 2'd1);
    assign w_chg  = |(w_level_nx ^ r_level);
    assign w_unused = &{1'b0, wdata};

    // Per-bit debounce: a level is accepted only after DB_SAMPLES consecutive differing ticks.
    always_comb begin
        w_level_nx = r_level;
        w_cnt_nx   = r_cnt;
        for (int i = 0; i < 16; i++) begin
            if (w_tick) begin
                if (r_sync2[i] != r_level[i]) begin
                    if (r_cnt[i] == 3'(DB_SAMPLES - 1)) begin
                        w_level_nx[i] = r_sync2[i];
                        w_cnt_nx[i]   = 3'd0;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] + 3'd1;
                    end
                end else begin
                    w_cnt_nx[i] = 3'd0;
                end
            end
        end
    end

    // Prescaler, two-flop synchroniser and debounce state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_cnt   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            r_level <= w_level_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Sticky rise flags: a new rise in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rise <= '0;
        else
            r_rise <= (w_rclr ? 16'h0000 : r_rise) | (w_level_nx & ~r_level);
    end

    // Change counter: written only on clear or change, so it otherwise holds its value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_chgcnt <= '0;
        else if (w_wr && addr == 2'd2)
            r_chgcnt <= '0;
        else if (w_chg)
            r_chgcnt <= r_chgcnt + 16'd1;
    end

`ifdef SW_IRQ_EN
    logic [15:0] r_mask;
    logic        r_irq;

    // Interrupt mask register and registered interrupt request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_mask <= (w_wr && addr == 2'd3) ? wdata[15:0] : r_mask;
            r_irq  <= |(r_rise & r_mask);
        end
    end

    assign w_mask = r_mask;
    assign irq    = r_irq;
`else
    assign w_mask = 16'h0000;
    assign irq    = 1'b0;
`endif

    // Read mux, zero outside a selected read.
    always_comb begin
        rdata = !w_rd         ? 32'h0 :
                addr == 2'd0  ? {16'h0, r_level} :
                addr == 2'd1  ? {16'h0, r_rise} :
                addr == 2'd2  ? {16'h0, r_chgcnt} :
                                {16'h0, w_mask};
    end
endmodule
